// File: rtl/uart_mmio_pkg.sv
// Shared register map, bit positions and serializer state encoding for the
// memory-mapped UART transmitter.
package uart_mmio_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_COUNT  = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam int CT_TXEN  = 0;
    localparam int CT_FLUSH = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra bit so full and empty
// are distinguishable when the index bits match.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store-fed byte FIFO, serializer and
// zero-latency status/control/frame-count readback.
module mmio_uart_tx
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Memwrite,
    input  logic [31:0] Memaddr,
    input  logic [31:0] MemWdata,
    output logic [31:0] MemRdata,
    output logic        sel,
    output logic        tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [31:0] count_q, count_d;
    logic        ovf_q;
    logic        txen_q;

    logic [1:0]  off;
    logic        wr, push, pop, flush, status_wr, ctrl_wr, bit_end;
    logic [7:0]  fifo_data;
    logic        full, empty;
    logic        unused_bits;

    assign sel       = (Memaddr[31:4] == BASE_ADDR[31:4]);
    assign off       = Memaddr[3:2];
    assign wr        = sel && Memwrite;
    assign push      = wr && (off == OFF_TXDATA);
    assign status_wr = wr && (off == OFF_STATUS);
    assign ctrl_wr   = wr && (off == OFF_CTRL);
    assign flush     = ctrl_wr && MemWdata[CT_FLUSH];
    assign bit_end   = (baud_q == BAUD_LAST);
    assign tx        = tx_q;
    assign unused_bits = ^{Memaddr[1:0], MemWdata[31:8]};

    uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .data_i (MemWdata[7:0]),
        .pop_i  (pop),
        .flush_i(flush),
        .data_o (fifo_data),
        .full_o (full),
        .empty_o(empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
        end
    end

    // Full is sampled before the edge, so a push into a full FIFO overflows
    // even when the serializer pops on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            txen_q <= 1'b1;
        end else begin
            if (push && full)                         ovf_q <= 1'b1;
            else if (status_wr && MemWdata[ST_OVF])   ovf_q <= 1'b0;
            if (ctrl_wr) txen_q <= MemWdata[CT_TXEN];
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        count_d = count_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (txen_q && !empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    count_d = count_q + 32'd1;
                    if (txen_q && !empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MemRdata = 32'h0;
        if (sel) begin
            case (off)
                OFF_STATUS: begin
                    MemRdata[ST_FULL]  = full;
                    MemRdata[ST_EMPTY] = empty;
                    MemRdata[ST_BUSY]  = (state_q != S_IDLE);
                    MemRdata[ST_OVF]   = ovf_q;
                end
                OFF_CTRL:  MemRdata[CT_TXEN] = txen_q;
                OFF_COUNT: MemRdata = count_q;
                default:   MemRdata = 32'h0;
            endcase
        end
    end

endmodule
